// File: rtl/pktbuf_rd_arbiter_pkg.sv
// Shared types for the packet-buffer read arbiter: source ids, arbiter states
// and the default read-credit depth.
package pktbuf_rd_arbiter_pkg;
  typedef enum logic {REQ_DM = 1'b0, REQ_AUX = 1'b1} req_src_t;
  typedef enum logic [1:0] {ST_IDLE = 2'd0, ST_GNT0 = 2'd1, ST_GNT1 = 2'd2} arb_state_t;
  localparam int PKTBUF_RD_MAX_OUTSTANDING = 8;
endpackage

// File: rtl/pktbuf_rd_tag_fifo.sv
// In-order FIFO of 1-bit source tags, one entry per issued-but-unreturned read.
// A push on a full FIFO is accepted only when a pop frees a slot that same cycle.
module pktbuf_rd_tag_fifo
  import pktbuf_rd_arbiter_pkg::*;
#(
  parameter int DEPTH = PKTBUF_RD_MAX_OUTSTANDING
) (
  input  logic     i_clk,
  input  logic     i_rst,
  input  logic     i_push,
  input  req_src_t i_push_src,
  input  logic     i_pop,
  output req_src_t o_pop_src,
  output logic     o_empty,
  output logic     o_full
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);

  logic [DEPTH-1:0] r_mem;
  logic [PW-1:0]    r_wr, r_rd;
  logic [CW-1:0]    r_cnt;
  logic             w_push, w_pop;

  assign o_empty   = (r_cnt == '0);
  assign o_full    = (r_cnt == CW'(DEPTH));
  assign o_pop_src = req_src_t'(r_mem[r_rd]);
  assign w_pop     = i_pop && !o_empty;
  assign w_push    = i_push && (!o_full || w_pop);

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_wr  <= '0;
      r_rd  <= '0;
      r_cnt <= '0;
    end else begin
      if (w_push) begin
        r_mem[r_wr] <= i_push_src;
        r_wr        <= (r_wr == PW'(DEPTH - 1)) ? '0 : r_wr + 1'b1;
      end
      if (w_pop)
        r_rd <= (r_rd == PW'(DEPTH - 1)) ? '0 : r_rd + 1'b1;
      r_cnt <= r_cnt + CW'(w_push) - CW'(w_pop);
    end
  end
endmodule

// File: rtl/pktbuf_rd_arbiter.sv
// Shares the packet-buffer read port between the data mover (0) and the aux
// reader (1): round-robin with burst lock, returns routed via an in-order tag FIFO.
module pktbuf_rd_arbiter
  import pktbuf_rd_arbiter_pkg::*;
#(
  parameter int AWIDTH          = 12,
  parameter int DWIDTH          = 64,
  parameter int MAX_OUTSTANDING = PKTBUF_RD_MAX_OUTSTANDING
) (
  input  logic              Clk,
  input  logic              Rst,
  input  logic              req0_read,
  input  logic [AWIDTH-1:0] req0_addr,
  input  logic              req0_last,
  output logic              req0_ready,
  output logic              req0_readvalid,
  output logic [DWIDTH-1:0] req0_readdata,
  input  logic              req1_read,
  input  logic [AWIDTH-1:0] req1_addr,
  input  logic              req1_last,
  output logic              req1_ready,
  output logic              req1_readvalid,
  output logic [DWIDTH-1:0] req1_readdata,
  output logic [AWIDTH-1:0] pkt_buffer_readaddress,
  output logic              pkt_buffer_read,
  input  logic              pkt_buffer_readvalid,
  input  logic [DWIDTH-1:0] pkt_buffer_readdata,
  output logic [31:0]       stats_grant0,
  output logic [31:0]       stats_grant1,
  output logic              protocol_err
);
  localparam int OW = $clog2(MAX_OUTSTANDING + 1);

  arb_state_t        r_state, w_state_nxt;
  req_src_t          r_last_served, w_acc_src, w_tag;
  logic [OW-1:0]     r_out, w_out_cap;
  logic              w_empty, w_full, w_pop, w_credit;
  logic              w_rdy0, w_rdy1, w_acc0, w_acc1, w_acc, w_acc_last;
  logic              r_rd, r_rv0, r_rv1, r_perr;
  logic [AWIDTH-1:0] r_addr;
  logic [DWIDTH-1:0] r_rdata;
  logic [31:0]       r_stats0, r_stats1;

  // A return in the same cycle frees its credit for an acceptance right away.
  assign w_pop     = pkt_buffer_readvalid && !w_empty;
  assign w_out_cap = r_out - OW'(w_pop);
  assign w_credit  = (w_out_cap < OW'(MAX_OUTSTANDING)) && (!w_full || w_pop);

  always_comb begin
    w_state_nxt = r_state;
    w_rdy0      = 1'b0;
    w_rdy1      = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (req0_read && req1_read)
          w_state_nxt = (r_last_served == REQ_DM) ? ST_GNT1 : ST_GNT0;
        else if (req0_read)
          w_state_nxt = ST_GNT0;
        else if (req1_read)
          w_state_nxt = ST_GNT1;
      end
      ST_GNT0: begin
        w_rdy0 = w_credit;
        if (req0_read && w_rdy0 && req0_last) w_state_nxt = ST_IDLE;
      end
      ST_GNT1: begin
        w_rdy1 = w_credit;
        if (req1_read && w_rdy1 && req1_last) w_state_nxt = ST_IDLE;
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  assign w_acc0     = req0_read && w_rdy0;
  assign w_acc1     = req1_read && w_rdy1;
  assign w_acc      = w_acc0 || w_acc1;
  assign w_acc_src  = w_acc1 ? REQ_AUX : REQ_DM;
  assign w_acc_last = w_acc1 ? req1_last : req0_last;

  pktbuf_rd_tag_fifo #(.DEPTH(MAX_OUTSTANDING)) u_tag_fifo (
    .i_clk      (Clk),
    .i_rst      (Rst),
    .i_push     (w_acc),
    .i_push_src (w_acc_src),
    .i_pop      (pkt_buffer_readvalid),
    .o_pop_src  (w_tag),
    .o_empty    (w_empty),
    .o_full     (w_full)
  );

  always_ff @(posedge Clk) begin
    if (Rst) begin
      r_state       <= ST_IDLE;
      r_last_served <= REQ_AUX;
      r_out         <= '0;
      r_rd          <= 1'b0;
      r_addr        <= '0;
      r_rv0         <= 1'b0;
      r_rv1         <= 1'b0;
      r_rdata       <= '0;
      r_stats0      <= '0;
      r_stats1      <= '0;
      r_perr        <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      if (w_acc && w_acc_last) begin
        r_last_served <= w_acc_src;
        if (w_acc_src == REQ_DM) r_stats0 <= r_stats0 + 32'd1;
        else                     r_stats1 <= r_stats1 + 32'd1;
      end
      r_out <= r_out + OW'(w_acc) - OW'(w_pop);
      r_rd  <= w_acc;
      if (w_acc) r_addr <= w_acc1 ? req1_addr : req0_addr;
      r_rv0 <= w_pop && (w_tag == REQ_DM);
      r_rv1 <= w_pop && (w_tag == REQ_AUX);
      if (w_pop) r_rdata <= pkt_buffer_readdata;
      // Orphan returns are dropped; the flag stays up until reset.
      if (pkt_buffer_readvalid && w_empty) r_perr <= 1'b1;
    end
  end

  assign req0_ready             = w_rdy0;
  assign req1_ready             = w_rdy1;
  assign req0_readvalid         = r_rv0;
  assign req1_readvalid         = r_rv1;
  assign req0_readdata          = r_rdata;
  assign req1_readdata          = r_rdata;
  assign pkt_buffer_read        = r_rd;
  assign pkt_buffer_readaddress = r_addr;
  assign stats_grant0           = r_stats0;
  assign stats_grant1           = r_stats1;
  assign protocol_err           = r_perr;
endmodule

// File: tb/tb_pktbuf_rd_arbiter.sv
// Bench for pktbuf_rd_arbiter: queue-based reference model of grants, tags and
// returns, a latency-configurable packet-buffer model, directed plus random traffic.
module tb_pktbuf_rd_arbiter;
  localparam int AW = 10, DW = 32, MAXO = 8;

  logic Clk = 1'b0, Rst;
  logic req0_read, req0_last, req0_ready, req0_readvalid;
  logic req1_read, req1_last, req1_ready, req1_readvalid;
  logic [AW-1:0] req0_addr, req1_addr, pkt_buffer_readaddress;
  logic [DW-1:0] req0_readdata, req1_readdata, pkt_buffer_readdata;
  logic pkt_buffer_read, pkt_buffer_readvalid, protocol_err;
  logic [31:0] stats_grant0, stats_grant1;

  always #5 Clk = ~Clk;

  pktbuf_rd_arbiter #(.AWIDTH(AW), .DWIDTH(DW), .MAX_OUTSTANDING(MAXO)) dut (
    .Clk(Clk), .Rst(Rst),
    .req0_read(req0_read), .req0_addr(req0_addr), .req0_last(req0_last), .req0_ready(req0_ready),
    .req0_readvalid(req0_readvalid), .req0_readdata(req0_readdata),
    .req1_read(req1_read), .req1_addr(req1_addr), .req1_last(req1_last), .req1_ready(req1_ready),
    .req1_readvalid(req1_readvalid), .req1_readdata(req1_readdata),
    .pkt_buffer_readaddress(pkt_buffer_readaddress), .pkt_buffer_read(pkt_buffer_read),
    .pkt_buffer_readvalid(pkt_buffer_readvalid), .pkt_buffer_readdata(pkt_buffer_readdata),
    .stats_grant0(stats_grant0), .stats_grant1(stats_grant1), .protocol_err(protocol_err)
  );

  int errors = 0, checks = 0, cyc = 0;

  // reference model: owner -1 means no burst lock
  int m_owner, m_last;
  int m_tags[$];
  logic [31:0] m_st0, m_st1;
  bit m_perr, m_rdy0, m_rdy1, e_rd, e_rv0, e_rv1;
  logic [AW-1:0] e_addr;
  logic [DW-1:0] e_data;

  // requesters: q_want = bursts still to start (-1 endless), q_blen 0 = random length
  int q_want[2], q_rem[2], q_blen[2], n_acc[2];
  logic [AW-1:0] q_addr[2];
  int done_q[$], src_q[$];

  // packet buffer: in-order returns, mem_credit -1 = unlimited, 0 = stalled
  int mem_due[$];
  logic [DW-1:0] mem_dat[$];
  int mem_credit, mem_lat;

  logic [5:0] obs, expv;
  assign obs  = {req0_ready, req1_ready, pkt_buffer_read, req0_readvalid, req1_readvalid, protocol_err};
  assign expv = {m_rdy0, m_rdy1, e_rd, e_rv0, e_rv1, m_perr};

  function automatic logic [DW-1:0] mem_word(input logic [AW-1:0] a);
    return (DW'(a) * 32'h0001_9E37) ^ 32'h0F0F_1357;
  endfunction

  task automatic model_reset();
    m_owner = -1; m_last = 1; m_tags.delete();
    m_st0 = '0; m_st1 = '0; m_perr = 0;
    e_rd = 0; e_rv0 = 0; e_rv1 = 0; e_addr = '0; e_data = '0;
  endtask

  task automatic clear_env();
    for (int i = 0; i < 2; i++) begin
      q_want[i] = 0; q_rem[i] = 0; q_blen[i] = 1; n_acc[i] = 0; q_addr[i] = '0;
    end
    mem_due.delete(); mem_dat.delete(); mem_credit = -1; mem_lat = 2;
    src_q.delete(); done_q.delete();
  endtask

  task automatic drive();
    int pop, cap;
    for (int i = 0; i < 2; i++)
      if (q_rem[i] == 0 && q_want[i] != 0) begin
        q_rem[i] = (q_blen[i] == 0) ? int'($urandom_range(1, 4)) : q_blen[i];
        if (q_want[i] > 0) q_want[i]--;
      end
    req0_read = (q_rem[0] > 0); req0_last = (q_rem[0] == 1); req0_addr = q_addr[0];
    req1_read = (q_rem[1] > 0); req1_last = (q_rem[1] == 1); req1_addr = q_addr[1];
    pkt_buffer_readvalid = 1'b0;
    if (mem_due.size() > 0 && mem_credit != 0)
      if (mem_due[0] <= cyc) pkt_buffer_readvalid = 1'b1;
    pkt_buffer_readdata = pkt_buffer_readvalid ? mem_dat[0] : DW'($urandom);
    pop = (pkt_buffer_readvalid && m_tags.size() > 0) ? 1 : 0;
    cap = m_tags.size() - pop;
    m_rdy0 = (m_owner == 0) && (cap < MAXO);
    m_rdy1 = (m_owner == 1) && (cap < MAXO);
  endtask

  task automatic advance();
    bit acc0, acc1;
    int t, due;
    acc0 = req0_read && m_rdy0;
    acc1 = req1_read && m_rdy1;
    if (pkt_buffer_readvalid) begin
      void'(mem_due.pop_front()); void'(mem_dat.pop_front());
      if (mem_credit > 0) mem_credit--;
    end
    if (pkt_buffer_read) begin
      due = cyc + ((mem_lat == 0) ? int'($urandom_range(1, 4)) : mem_lat);
      if (mem_due.size() > 0 && due < mem_due[$]) due = mem_due[$];
      mem_due.push_back(due);
      mem_dat.push_back(mem_word(pkt_buffer_readaddress));
    end
    if (req0_readvalid) src_q.push_back(0);
    if (req1_readvalid) src_q.push_back(1);
    if (Rst) model_reset();
    else begin
      e_rv0 = 0; e_rv1 = 0;
      if (pkt_buffer_readvalid) begin
        if (m_tags.size() > 0) begin
          t = m_tags.pop_front();
          e_rv0 = (t == 0); e_rv1 = (t == 1); e_data = pkt_buffer_readdata;
        end else m_perr = 1;
      end
      e_rd = acc0 || acc1;
      if (acc0) begin e_addr = req0_addr; m_tags.push_back(0); end
      if (acc1) begin e_addr = req1_addr; m_tags.push_back(1); end
      if (m_owner < 0) begin
        if (req0_read && req1_read) m_owner = 1 - m_last;
        else if (req0_read) m_owner = 0;
        else if (req1_read) m_owner = 1;
      end else if ((acc0 && req0_last) || (acc1 && req1_last)) begin
        m_last = m_owner;
        if (m_owner == 0) m_st0 = m_st0 + 1; else m_st1 = m_st1 + 1;
        done_q.push_back(m_owner);
        m_owner = -1;
      end
    end
    if (acc0) begin q_rem[0]--; q_addr[0]++; n_acc[0]++; end
    if (acc1) begin q_rem[1]--; q_addr[1]++; n_acc[1]++; end
    @(posedge Clk); #1; cyc++;
  endtask

  task automatic do_reset();
    clear_env();
    Rst = 1'b1; drive(); @(negedge Clk); advance(); Rst = 1'b0;
  endtask

  task automatic test_reset();
    Rst = 1'b1; clear_env(); model_reset();
    @(posedge Clk); #1;
    repeat (3) begin
      drive(); @(negedge Clk);
      checks++;
      if ({obs, stats_grant0, stats_grant1} !== 70'd0) begin
        errors++; $display("FAIL reset flags/stats got=%b/%0d/%0d exp=0/0/0", obs, stats_grant0, stats_grant1);
      end
      advance();
    end
    Rst = 1'b0;
  endtask

  task automatic test_single_burst();
    do_reset();
    q_addr[0] = 10; q_blen[0] = 3; q_want[0] = 1;
    repeat (14) begin
      drive(); @(negedge Clk);
      checks++;
      if ({obs, stats_grant0, stats_grant1} !== {expv, m_st0, m_st1}) begin
        errors++; $display("FAIL single_burst cyc=%0d flags/s0/s1 got=%b/%0d/%0d exp=%b/%0d/%0d", cyc, obs, stats_grant0, stats_grant1, expv, m_st0, m_st1);
      end
      if (e_rd) begin
        checks++;
        if (pkt_buffer_readaddress !== e_addr) begin errors++; $display("FAIL single_burst_addr got=%0d exp=%0d", pkt_buffer_readaddress, e_addr); end
      end
      if (e_rv0) begin
        checks++;
        if (req0_readdata !== e_data) begin errors++; $display("FAIL single_burst_data got=%h exp=%h", req0_readdata, e_data); end
      end
      advance();
    end
    checks++;
    if (stats_grant0 !== 32'd1 || src_q.size() != 3 || src_q.sum() != 0) begin
      errors++; $display("FAIL single_burst_summary stats0=%0d returns=%0d exp stats0=1 returns=3 all to req0", stats_grant0, src_q.size());
    end
  endtask

  task automatic test_contention();
    do_reset();
    q_want = '{2, 2}; q_blen = '{2, 2}; q_addr[0] = 40; q_addr[1] = 80;
    repeat (22) begin
      drive(); @(negedge Clk);
      checks++;
      if ({obs, stats_grant0, stats_grant1} !== {expv, m_st0, m_st1}) begin
        errors++; $display("FAIL contention cyc=%0d flags/s0/s1 got=%b/%0d/%0d exp=%b/%0d/%0d", cyc, obs, stats_grant0, stats_grant1, expv, m_st0, m_st1);
      end
      if (e_rd) begin
        checks++;
        if (pkt_buffer_readaddress !== e_addr) begin errors++; $display("FAIL contention_addr got=%0d exp=%0d", pkt_buffer_readaddress, e_addr); end
      end
      advance();
    end
    checks++;
    if (stats_grant0 !== 32'd2 || stats_grant1 !== 32'd2 || done_q.size() != 4 ||
        done_q[0] != 0 || done_q[1] != 1 || done_q[2] != 0 || done_q[3] != 1) begin
      errors++; $display("FAIL contention_order stats=%0d/%0d bursts=%0d exp stats=2/2 order 0,1,0,1", stats_grant0, stats_grant1, done_q.size());
    end
  endtask

  task automatic test_credit_limit();
    do_reset();
    q_want[0] = 1; q_blen[0] = 20; q_addr[0] = 500; mem_credit = 0;
    for (int k = 0; k < 60; k++) begin
      if (k == 14) mem_credit = 1;
      if (k == 20) mem_credit = -1;
      drive(); @(negedge Clk);
      checks++;
      if ({obs, stats_grant0, stats_grant1} !== {expv, m_st0, m_st1}) begin
        errors++; $display("FAIL credit cyc=%0d flags/s0/s1 got=%b/%0d/%0d exp=%b/%0d/%0d", cyc, obs, stats_grant0, stats_grant1, expv, m_st0, m_st1);
      end
      if (e_rv0) begin
        checks++;
        if (req0_readdata !== e_data) begin errors++; $display("FAIL credit_data got=%h exp=%h", req0_readdata, e_data); end
      end
      if (k == 13) begin
        checks++;
        if (n_acc[0] != MAXO || req0_ready !== 1'b0) begin errors++; $display("FAIL credit_cap accepted=%0d ready=%b exp 8/0", n_acc[0], req0_ready); end
      end
      if (k == 14) begin
        checks++;
        if (req0_ready !== 1'b1) begin errors++; $display("FAIL credit_reopen ready=%b exp 1", req0_ready); end
      end
      if (k == 19) begin
        checks++;
        if (n_acc[0] != MAXO + 1) begin errors++; $display("FAIL credit_ninth accepted=%0d exp 9", n_acc[0]); end
      end
      advance();
    end
  endtask

  task automatic test_interleaved();
    do_reset();
    q_want = '{1, 1}; q_blen = '{2, 2}; q_addr[0] = 100; q_addr[1] = 200; mem_credit = 0;
    for (int k = 0; k < 24; k++) begin
      if (k == 12) begin mem_credit = -1; src_q.delete(); end
      drive(); @(negedge Clk);
      checks++;
      if ({obs, stats_grant0, stats_grant1} !== {expv, m_st0, m_st1}) begin
        errors++; $display("FAIL interleaved cyc=%0d flags/s0/s1 got=%b/%0d/%0d exp=%b/%0d/%0d", cyc, obs, stats_grant0, stats_grant1, expv, m_st0, m_st1);
      end
      if (e_rv0 || e_rv1) begin
        checks++;
        if ((e_rv0 ? req0_readdata : req1_readdata) !== e_data) begin
          errors++; $display("FAIL interleaved_data got=%h/%h exp=%h", req0_readdata, req1_readdata, e_data);
        end
      end
      advance();
    end
    checks++;
    if (src_q.size() != 4 || src_q[0] != 0 || src_q[1] != 0 || src_q[2] != 1 || src_q[3] != 1) begin
      errors++; $display("FAIL interleaved_order returns=%0d exp order 0,0,1,1", src_q.size());
    end
  endtask

  task automatic test_spurious();
    do_reset();
    mem_due.push_back(cyc + 1); mem_dat.push_back(32'hDEAD_BEEF);
    for (int k = 0; k < 40; k++) begin
      if (k == 6) begin q_want[0] = 1; q_blen[0] = 9; q_addr[0] = 600; mem_credit = 0; end
      if (k == 20) mem_credit = -1;
      drive(); @(negedge Clk);
      checks++;
      if ({obs, stats_grant0, stats_grant1} !== {expv, m_st0, m_st1}) begin
        errors++; $display("FAIL spurious cyc=%0d flags/s0/s1 got=%b/%0d/%0d exp=%b/%0d/%0d", cyc, obs, stats_grant0, stats_grant1, expv, m_st0, m_st1);
      end
      if (k == 5) begin
        checks++;
        if (protocol_err !== 1'b1 || src_q.size() != 0) begin errors++; $display("FAIL spurious_flag err=%b returns=%0d exp 1/0", protocol_err, src_q.size()); end
      end
      if (k == 19) begin
        checks++;
        if (n_acc[0] != MAXO || protocol_err !== 1'b1) begin errors++; $display("FAIL spurious_credit accepted=%0d err=%b exp 8/1", n_acc[0], protocol_err); end
      end
      advance();
    end
  endtask

  task automatic test_reset_mid_burst();
    int k;
    do_reset();
    q_want[1] = 1; q_blen[1] = 6; q_addr[1] = 300; mem_credit = 0;
    k = 0;
    while (n_acc[1] < 3 && k < 20) begin
      drive(); @(negedge Clk);
      checks++;
      if ({obs, stats_grant0, stats_grant1} !== {expv, m_st0, m_st1}) begin
        errors++; $display("FAIL midrst_pre cyc=%0d flags/s0/s1 got=%b/%0d/%0d exp=%b/%0d/%0d", cyc, obs, stats_grant0, stats_grant1, expv, m_st0, m_st1);
      end
      advance(); k++;
    end
    checks++;
    if (n_acc[1] != 3) begin errors++; $display("FAIL midrst_wait accepted=%0d exp 3 within 20 cycles", n_acc[1]); end
    Rst = 1'b1; drive(); @(negedge Clk); advance(); Rst = 1'b0;
    clear_env();
    mem_credit = 0;
    for (int j = 0; j < 40; j++) begin
      if (j == 2) begin q_want[0] = 1; q_blen[0] = 9; q_addr[0] = 700; end
      if (j == 16) mem_credit = -1;
      drive(); @(negedge Clk);
      checks++;
      if ({obs, stats_grant0, stats_grant1} !== {expv, m_st0, m_st1}) begin
        errors++; $display("FAIL midrst_post cyc=%0d flags/s0/s1 got=%b/%0d/%0d exp=%b/%0d/%0d", cyc, obs, stats_grant0, stats_grant1, expv, m_st0, m_st1);
      end
      if (j == 0) begin
        checks++;
        if ({obs, stats_grant0, stats_grant1} !== 70'd0) begin errors++; $display("FAIL midrst_clear flags=%b s1=%0d exp all 0", obs, stats_grant1); end
      end
      if (j == 15) begin
        checks++;
        if (n_acc[0] != MAXO) begin errors++; $display("FAIL midrst_credit accepted=%0d exp 8", n_acc[0]); end
      end
      advance();
    end
  endtask

  task automatic test_random();
    do_reset();
    q_blen = '{0, 0}; mem_lat = 0; q_addr[0] = 0; q_addr[1] = 512;
    for (int k = 0; k < 3040; k++) begin
      if (k < 3000) begin
        for (int i = 0; i < 2; i++)
          if ($urandom_range(0, 7) == 0) q_want[i] = ($urandom_range(0, 2) != 0) ? -1 : 0;
        mem_credit = ($urandom_range(0, 3) == 0) ? 0 : -1;
      end else begin
        q_want = '{0, 0}; mem_credit = -1;
      end
      drive(); @(negedge Clk);
      checks++;
      if ({obs, stats_grant0, stats_grant1} !== {expv, m_st0, m_st1}) begin
        errors++; $display("FAIL random cyc=%0d flags/s0/s1 got=%b/%0d/%0d exp=%b/%0d/%0d", cyc, obs, stats_grant0, stats_grant1, expv, m_st0, m_st1);
      end
      if (e_rd) begin
        checks++;
        if (pkt_buffer_readaddress !== e_addr) begin errors++; $display("FAIL random_addr cyc=%0d got=%0d exp=%0d", cyc, pkt_buffer_readaddress, e_addr); end
      end
      if (e_rv0 || e_rv1) begin
        checks++;
        if ((e_rv0 ? req0_readdata : req1_readdata) !== e_data) begin
          errors++; $display("FAIL random_data cyc=%0d got=%h/%h exp=%h", cyc, req0_readdata, req1_readdata, e_data);
        end
      end
      advance();
    end
    checks++;
    if (src_q.size() != n_acc[0] + n_acc[1]) begin
      errors++; $display("FAIL random_returns delivered=%0d exp=%0d", src_q.size(), n_acc[0] + n_acc[1]);
    end
  endtask

  initial begin
    req0_read = 0; req0_last = 0; req0_addr = '0;
    req1_read = 0; req1_last = 0; req1_addr = '0;
    pkt_buffer_readvalid = 0; pkt_buffer_readdata = '0;
    test_reset();
    test_single_burst();
    test_contention();
    test_credit_limit();
    test_interleaved();
    test_spurious();
    test_reset_mid_burst();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
